d7s_capture: RTL
================

D7S_CAPTURE -- requirements
Module: d7s_capture

Interface
REQ-001 Parameter STABLE_CYCLES, default 16: consecutive synchronized cycles a pattern SHALL hold before capture (range 2..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 2_000_000: cycles without a completed frame before no_signal SHALL assert.
REQ-003 CLK100MHZ  input  1  sole clock, rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 AN  input  8  multiplexed anode selects, active-low, bit i = digit i.
REQ-006 D7S  input  7  segment lines, active-low, D7S[0]=a … D7S[6]=g.
REQ-007 frame_valid  output  1  one-cycle pulse when a full 8-digit frame is published.
REQ-008 sym_out  output  40  decoded symbol per digit, digit i at [5i+4:5i].
REQ-009 seg_out  output  56  raw active-low segments per digit, digit i at [7i+6:7i].
REQ-010 frame_count  output  16  published frames, wraps 16'hFFFF→0.
REQ-011 an_error  output  1  sticky illegal-anode flag.
REQ-012 no_signal  output  1  timeout flag.

Function
REQ-013 AN and D7S SHALL pass through a 2-flop synchronizer; all logic SHALL use synchronized values only.
REQ-014 A sample SHALL be valid when AN has exactly one 0; all-ones AN SHALL be idle; more than one 0 SHALL be illegal.
REQ-015 Stability counter SHALL increment (saturating) while {AN,D7S} equals the previous synchronized sample, and SHALL clear on any change.
REQ-016 A valid sample SHALL be captured exactly once per dwell, in the cycle the counter reaches STABLE_CYCLES-1; the digit's raw segments SHALL be written to the internal buffer and its seen bit set.
REQ-017 Recapture of an already-seen digit before frame completion SHALL overwrite its buffer entry; seen SHALL stay set.
REQ-018 Idle or changing samples SHALL never be captured.
REQ-019 The cycle after the capture that makes seen==8'hFF, the block SHALL update seg_out and sym_out from the buffer, pulse frame_valid, increment frame_count, and clear seen.
REQ-020 Latency: eighth digit stable at pins from cycle t → frame_valid high at cycle t+STABLE_CYCLES+3.
REQ-021 Decode D7S[6:0]→symbol: 40→00, 79→01, 24→02, 30→03, 19→04, 12→05, 02→06, 78→07, 00→08, 10→09, 08→0A, 03→0B, 46→0C, 21→0D, 06→0E, 0E→0F, 7F→10 (blank), 09→11 (H), 48→12 (n); any other → 1F (unknown).
REQ-022 An illegal sample stable for STABLE_CYCLES SHALL set an_error, which SHALL clear only on reset.
REQ-023 Timeout counter SHALL clear on frame_valid and otherwise increment saturating; no_signal SHALL be 1 while counter ≥ TIMEOUT_CYCLES-1, and SHALL drop in the frame_valid cycle.
REQ-024 Sequential logic SHALL be a capture FSM: IDLE (no valid dwell), DWELL (counting), HELD (captured, awaiting change), PUBLISH (one cycle, frame_valid); any input change from DWELL/HELD SHALL return to IDLE or restart DWELL.

Reset
REQ-025 On reset: frame_valid=0, frame_count=0, an_error=0, no_signal=0, seen=0, FSM=IDLE, sym_out fields=5'h10, seg_out=all ones, synchronizers=all ones, counters=0.
REQ-026 Reset asserted mid-frame SHALL discard all partial captures; a complete new frame SHALL be required.

Verification
REQ-027 Reset pulse → all outputs at REQ-025 values, no frame_valid for 100 idle cycles.
REQ-028 Scan digits 0..7 with D7S 10,21,7F,09,48,7F,09,03 each held 100 cycles → one frame_valid; sym_out digits 0..7 = 09,0D,10,11,12,10,11,0B; frame_count=1.
REQ-029 Within a scan, corrupt digit 3 to D7S=00 for 10 cycles then restore → no capture of 00; sym_out digit 3 = 11.
REQ-030 AN=8'b11111100 held 20 cycles → an_error=1, seen unchanged; subsequent valid frame still publishes, an_error stays 1.
REQ-031 TIMEOUT_CYCLES=1000, idle AN for 1000 cycles → no_signal=1; next full scan → no_signal=0 in the frame_valid cycle.
REQ-032 Capture digits 0..4, assert reset, resume with digits 5..7 only → no frame_valid until digits 0..4 are rescanned.

Source files
------------

// File: rtl/d7s_capture.sv
// Seven-segment display sniffer: watches a multiplexed 8-digit display, debounces
// each digit dwell and publishes whole frames of raw segments and decoded symbols.
module d7s_capture #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic        CLK100MHZ,
    input  logic        reset,
    input  logic [7:0]  AN,
    input  logic [6:0]  D7S,
    output logic        frame_valid,
    output logic [39:0] sym_out,
    output logic [55:0] seg_out,
    output logic [15:0] frame_count,
    output logic        an_error,
    output logic        no_signal
);
    localparam int              NUM_DIG  = 8;
    localparam logic [7:0]      STB_LAST = 8'(STABLE_CYCLES - 1);
    localparam int              TO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DWELL, HELD, PUBLISH} state_t;

    function automatic logic [4:0] seg2sym(input logic [6:0] s);
        case (s)
            7'h40: seg2sym = 5'h00;
            7'h79: seg2sym = 5'h01;
            7'h24: seg2sym = 5'h02;
            7'h30: seg2sym = 5'h03;
            7'h19: seg2sym = 5'h04;
            7'h12: seg2sym = 5'h05;
            7'h02: seg2sym = 5'h06;
            7'h78: seg2sym = 5'h07;
            7'h00: seg2sym = 5'h08;
            7'h10: seg2sym = 5'h09;
            7'h08: seg2sym = 5'h0A;
            7'h03: seg2sym = 5'h0B;
            7'h46: seg2sym = 5'h0C;
            7'h21: seg2sym = 5'h0D;
            7'h06: seg2sym = 5'h0E;
            7'h0E: seg2sym = 5'h0F;
            7'h7F: seg2sym = 5'h10;
            7'h09: seg2sym = 5'h11;
            7'h48: seg2sym = 5'h12;
            default: seg2sym = 5'h1F;
        endcase
    endfunction

    logic [7:0]              an_s1, an_s2, an_p;
    logic [6:0]              d_s1, d_s2, d_p;
    logic [7:0]              stb_cnt;
    logic [TO_W-1:0]         to_cnt;
    logic [NUM_DIG-1:0]      seen, cap_mask;
    logic [NUM_DIG-1:0][6:0] buf_q, buf_nxt;
    logic [39:0]             sym_nxt;
    state_t                  state, state_nxt;
    logic                    same, new_vld, cur_vld, cur_idle, cap, cap_illegal, publish;

    // an_p/d_p is the previous synchronized sample; the dwell being judged
    assign same        = ({an_s2, d_s2} == {an_p, d_p});
    assign new_vld     = $onehot(~an_s2);
    assign cur_vld     = $onehot(~an_p);
    assign cur_idle    = &an_p;
    assign cap         = (state == DWELL) && same && (stb_cnt == STB_LAST) && cur_vld;
    assign cap_illegal = same && (stb_cnt == STB_LAST) && !cur_vld && !cur_idle;
    assign publish     = cap && (&(seen | cap_mask));
    assign no_signal   = (to_cnt >= TO_LAST);

    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
        assign cap_mask[g]        = cap & ~an_p[g];
        assign buf_nxt[g]         = cap_mask[g] ? d_p : buf_q[g];
        assign sym_nxt[5*g +: 5]  = seg2sym(buf_nxt[g]);
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            an_s1   <= '1;
            an_s2   <= '1;
            an_p    <= '1;
            d_s1    <= '1;
            d_s2    <= '1;
            d_p     <= '1;
            stb_cnt <= '0;
        end else begin
            an_s1   <= AN;
            an_s2   <= an_s1;
            an_p    <= an_s2;
            d_s1    <= D7S;
            d_s2    <= d_s1;
            d_p     <= d_s2;
            if (!same)
                stb_cnt <= '0;
            else if (stb_cnt != 8'hFF)
                stb_cnt <= stb_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            buf_q       <= '1;
            seen        <= '0;
            seg_out     <= '1;
            sym_out     <= {NUM_DIG{5'h10}};
            frame_count <= '0;
            an_error    <= 1'b0;
            to_cnt      <= '0;
        end else begin
            state <= state_nxt;
            buf_q <= buf_nxt;
            // outputs load the merged buffer so the eighth digit lands in the same frame
            if (publish) begin
                seen        <= '0;
                seg_out     <= buf_nxt;
                sym_out     <= sym_nxt;
                frame_count <= frame_count + 16'd1;
                to_cnt      <= '0;
            end else begin
                seen <= seen | cap_mask;
                if (to_cnt < TO_LAST)
                    to_cnt <= to_cnt + 1'b1;
            end
            if (cap_illegal)
                an_error <= 1'b1;
        end
    end

    always_comb begin
        state_nxt   = state;
        frame_valid = (state == PUBLISH);
        if (publish)
            state_nxt = PUBLISH;
        else if (!same)
            state_nxt = new_vld ? DWELL : IDLE;
        else begin
            case (state)
                DWELL:   if (cap) state_nxt = HELD;
                PUBLISH: state_nxt = HELD;
                default: state_nxt = state;
            endcase
        end
    end
endmodule
